// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer: FSM encoding
// and the packed control word that drives the stage enables and flushes.
package hazard_pkg;

  localparam int REG_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } state_t;

  typedef struct packed {
    logic pcwrite;
    logic ifidwrite;
    logic idexwrite;
    logic exmemwrite;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } ctrl_t;

  // Fields in order: pc, ifid, idex, exmem enables, ifid_flush, idex_flush, memwb_bubble.
  localparam ctrl_t CTRL_DEFAULT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BRANCH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LOADUSE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_OFF     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush arbiter for the 5-stage pipeline: dmem wait freeze, taken-branch
// flush and load-use stall, plus a dmem timeout watchdog and event counters.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int REG_W       = REG_W_DEFAULT,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             exmem_branch_taken,
  input  logic             exmem_memreq,
  input  logic             dmem_ready,
  output logic             pcwrite,
  output logic             ifidwrite,
  output logic             idexwrite,
  output logic             exmemwrite,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output state_t           fsm_state
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            err_nxt;
  logic            memstall, loaduse;
  logic            resolve, flush_inc, stall_inc;
  ctrl_t           ctrl;

  assign memstall = exmem_memreq & ~dmem_ready;
  assign loaduse  = idex_memread & (idex_rt != '0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= err_nxt;
    end
  end

  always_comb begin
    ctrl      = CTRL_DEFAULT;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = mem_err;
    resolve   = 1'b0;
    flush_inc = 1'b0;
    stall_inc = 1'b0;
    case (state)
      RUN: begin
        if (memstall) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = MEMWAIT;
          wait_nxt  = WC_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      MEMWAIT: begin
        if (!dmem_ready) begin
          ctrl     = CTRL_FREEZE;
          wait_nxt = wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
          end
        end else begin
          resolve   = 1'b1;
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      ERROR: ctrl = CTRL_FREEZE;
      default: begin
        ctrl      = CTRL_FREEZE;
        state_nxt = RUN;
      end
    endcase
    // Branch and load-use only resolve in cycles where memory is not holding the pipe.
    if (resolve) begin
      if (exmem_branch_taken) begin
        ctrl      = CTRL_BRANCH;
        flush_inc = 1'b1;
      end else if (loaduse) begin
        ctrl      = CTRL_LOADUSE;
        stall_inc = 1'b1;
      end
    end
    if (!rst_n) begin
      ctrl = CTRL_OFF;
    end
  end

  assign {pcwrite, ifidwrite, idexwrite, exmemwrite,
          ifid_flush, idex_flush, memwb_bubble} = ctrl;
  assign fsm_state = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (flush_inc),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios then random traffic, each
// cycle compared against a rule-level model of the hazard arbitration.
module tb_hazard_sequencer;
  import hazard_pkg::*;

  localparam int REG_W       = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rt, ifid_rs, ifid_rt;
  logic             exmem_branch_taken, exmem_memreq, dmem_ready;
  logic             pcwrite, ifidwrite, idexwrite, exmemwrite;
  logic             ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  state_t           fsm_state;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: consecutive frozen cycles, sticky error, plain integer counters.
  int m_waits = 0;
  bit m_err   = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(
    .REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_branch_taken(exmem_branch_taken), .exmem_memreq(exmem_memreq),
    .dmem_ready(dmem_ready),
    .pcwrite(pcwrite), .ifidwrite(ifidwrite), .idexwrite(idexwrite),
    .exmemwrite(exmemwrite), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fsm_state(fsm_state)
  );

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_frozen();
    if (m_err) return 1'b1;
    if (m_waits > 0) return !dmem_ready;
    return exmem_memreq && !dmem_ready;
  endfunction

  // Compare every output against the model for the inputs currently applied.
  task automatic check_now(input string tag);
    bit fz, lu, br, st, on;
    logic [31:0] exp_state;
    on = rst_n;
    fz = model_frozen();
    lu = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    br = !fz && exmem_branch_taken;
    st = !fz && !exmem_branch_taken && lu;
    exp_state = m_err ? 32'd2 : (m_waits > 0 ? 32'd1 : 32'd0);
    compare({tag, ".pcwrite"},      pcwrite,      on && !fz && !st);
    compare({tag, ".ifidwrite"},    ifidwrite,    on && !fz && !st);
    compare({tag, ".idexwrite"},    idexwrite,    on && !fz);
    compare({tag, ".exmemwrite"},   exmemwrite,   on && !fz);
    compare({tag, ".ifid_flush"},   ifid_flush,   on && br);
    compare({tag, ".idex_flush"},   idex_flush,   on && (br || st));
    compare({tag, ".memwb_bubble"}, memwb_bubble, on && fz);
    compare({tag, ".mem_err"},      mem_err,      m_err);
    compare({tag, ".stall_cnt"},    stall_cnt,    m_stall);
    compare({tag, ".flush_cnt"},    flush_cnt,    m_flush);
    compare({tag, ".state"},        fsm_state,    exp_state);
  endtask

  task automatic model_clock();
    bit fz, lu;
    fz = model_frozen();
    lu = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    if (fz) begin
      if (!m_err) begin
        m_waits++;
        if (m_waits >= MEM_TIMEOUT) m_err = 1;
      end
    end else begin
      m_waits = 0;
      if (exmem_branch_taken) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      else if (lu) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
    end
  endtask

  task automatic drive(input bit mr, input int rt_l, input int rs, input int rt,
                       input bit br, input bit mq, input bit rdy);
    idex_memread       = mr;
    idex_rt            = REG_W'(rt_l);
    ifid_rs            = REG_W'(rs);
    ifid_rt            = REG_W'(rt);
    exmem_branch_taken = br;
    exmem_memreq       = mq;
    dmem_ready         = rdy;
  endtask

  // One clock: check mid-cycle, then advance model and DUT across the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_now(tag);
    model_clock();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted away from any clock edge, checked before the next edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_waits = 0; m_err = 0; m_stall = 0; m_flush = 0;
    #2;
    check_now(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    do_reset("reset");

    drive(1, 8, 8, 3, 0, 0, 1);  cycle("loaduse");
    drive(0, 8, 8, 3, 0, 0, 1);  cycle("after_loaduse");
    drive(1, 0, 5, 0, 0, 0, 1);  cycle("zero_reg");
    drive(1, 9, 2, 9, 1, 0, 1);  cycle("branch_beats_lu");
    drive(0, 0, 0, 0, 0, 0, 1);  cycle("after_branch");

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0); cycle("memwait");
    end
    drive(0, 0, 0, 0, 0, 1, 1);  cycle("release");
    drive(0, 0, 0, 0, 0, 0, 1);  cycle("back_to_run");

    drive(0, 0, 0, 0, 1, 1, 0);  cycle("stall_with_branch");
    drive(0, 0, 0, 0, 1, 1, 1);  cycle("branch_on_release");

    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0); cycle("timeout_wait");
    end
    compare("timeout.mem_err_set", mem_err, 1'b1);
    drive(1, 4, 4, 0, 1, 1, 1);  cycle("error_ignores_ready");
    drive(0, 0, 0, 0, 0, 0, 1);  cycle("error_holds");
    do_reset("reset_from_error");

    drive(0, 0, 0, 0, 0, 1, 0);  cycle("wait_then_reset");
    cycle("wait_then_reset2");
    do_reset("reset_mid_wait");

    for (int i = 0; i < 5; i++) begin
      drive(1, 7, 1, 7, 0, 0, 1); cycle("sat_lu");
      drive(0, 0, 0, 0, 0, 0, 1); cycle("sat_gap");
    end
    compare("saturation.stall_cnt", stall_cnt, 2'd3);
    do_reset("reset_before_random");

    for (int n = 0; n < 500; n++) begin
      bit mq, rdy;
      if (m_err && $urandom_range(0, 3) == 0) begin
        do_reset("rand_reset");
      end
      mq  = (m_waits > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), ($urandom_range(0, 4) == 0), mq, rdy);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Replaces standalone load-use detection by arbitrating three hazard sources: multi-cycle data-memory wait, taken-branch flush and load-use stall.
- Drives per-stage write enables and flush controls.
- Runs a timeout watchdog on data memory and keeps saturating performance counters.

Parameters:
- REG_W, 5, register-index width
- MEM_TIMEOUT, 64, max consecutive dmem wait cycles before error (≥2)
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- idex_memread  input  1  instruction in ID/EX is a load
- idex_rt  input  REG_W  load destination in ID/EX
- ifid_rs  input  REG_W  source rs of instruction in IF/ID
- ifid_rt  input  REG_W  source rt of instruction in IF/ID
- exmem_branch_taken  input  1  branch in EX/MEM resolved taken
- exmem_memreq  input  1  EX/MEM instruction accesses data memory (load or store)
- dmem_ready  input  1  data memory completes access this cycle
- pcwrite  output  1  PC register enable
- ifidwrite  output  1  IF/ID enable
- idexwrite  output  1  ID/EX enable
- exmemwrite  output  1  EX/MEM enable
- ifid_flush  output  1  load NOP into IF/ID
- idex_flush  output  1  select zero control word into ID/EX (bubble)
- memwb_bubble  output  1  load NOP into MEM/WB
- mem_err  output  1  sticky dmem timeout flag
- stall_cnt  output  CNT_W  load-use stall cycles, saturating
- flush_cnt  output  CNT_W  branch flush events, saturating

Behaviour:
- States: RUN, MEMWAIT, ERROR. Outputs are Mealy: a function of state and current inputs, with no added latency.
- During reset (rst_n low):
  - state is RUN; wait_cnt, stall_cnt, flush_cnt and mem_err are 0.
  - all write enables are 0; all flush/bubble outputs are 0.
- Hazard terms:
  - memstall = exmem_memreq & !dmem_ready.
  - loaduse = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt). A load to $zero never stalls.
- Default output set (no hazard): all write enables 1; ifid_flush, idex_flush and memwb_bubble all 0.
- RUN, evaluated in strict priority order:
  1. memstall: freeze. pcwrite, ifidwrite, idexwrite and exmemwrite are 0; memwb_bubble is 1; flushes are 0. Next state MEMWAIT, wait_cnt = 1. A pending branch or load-use is ignored this cycle and re-evaluated after release.
  2. exmem_branch_taken: all enables 1, ifid_flush 1, idex_flush 1. The load-use term is suppressed. flush_cnt increments.
  3. loaduse: pcwrite 0, ifidwrite 0, idex_flush 1; idexwrite and exmemwrite stay 1. stall_cnt increments. Single cycle, with no state change; the hazard term clears once the load advances.
  4. Otherwise: default output set.
- MEMWAIT:
  - If dmem_ready = 0: outputs are frozen as in RUN case 1; wait_cnt increments.
    - When wait_cnt == MEM_TIMEOUT−1 and dmem_ready is still 0, next state is ERROR and mem_err is set.
  - If dmem_ready = 1: outputs follow RUN rules 2–4 that same cycle (release cycle); next state RUN; wait_cnt cleared.
- ERROR:
  - Pipeline frozen: outputs as in RUN case 1.
  - mem_err stays 1. The only exit is rst_n.
  - Counters hold.
- Counters:
  - Saturate at all-ones; no wrap.
  - A branch flush and a load-use in the same cycle count only the flush.
  - Nothing counts during memstall or ERROR.
- Reset mid-MEMWAIT: immediate asynchronous return to RUN; counters and mem_err are cleared.
- Simultaneous memstall and branch: freeze wins. The branch remains in EX/MEM and flushes on the release cycle.

Decomposition:
- hazard_pkg holds:
  - state encoding: RUN = 2'd0, MEMWAIT = 2'd1, ERROR = 2'd2
  - REG_W default
  - default output-set constants
- One sub-module, sat_counter: parameter CNT_W; ports clk, rst_n, inc, count. Instantiated twice.
- The wait counter stays inline, width $clog2(MEM_TIMEOUT)+1.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8, dmem_ready=1 → one cycle with pcwrite=0, ifidwrite=0, idex_flush=1; stall_cnt=1. The next cycle (memread=0) is the default set.
- $zero: idex_memread=1, idex_rt=0, ifid_rt=0 → no stall; stall_cnt stays 0.
- Branch beats load-use: exmem_branch_taken=1 together with a load-use match → ifid_flush=1, idex_flush=1, pcwrite=1; flush_cnt=1, stall_cnt=0.
- Memory wait: exmem_memreq=1, dmem_ready=0 for 3 cycles then 1 → 3 frozen cycles (enables 0, memwb_bubble=1), then the release cycle with the default set; state returns to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → mem_err=1 after 4th wait cycle; outputs stay frozen even after dmem_ready=1. Asserting rst_n low clears everything.
- Saturation: CNT_W=2, 5 load-use stalls → stall_cnt=3.
